// File: rtl/cordic_rot_sequencer.sv
// Iterative CORDIC rotation sequencer: one micro-rotation per clock.
// Optional gain compensation stage: CORDIC_ROT_SEQ_SCALE_COMP_EN.
module cordic_rot_sequencer #(
  parameter int CORDIC_WIDTH = 22,
  parameter int N_ITER       = 16
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CORDIC_WIDTH-1:0] x_in,
  input  logic [CORDIC_WIDTH-1:0] y_in,
  input  logic [N_ITER-1:0]       microRot_dir_in,
  output logic [CORDIC_WIDTH-1:0] x_out,
  output logic [CORDIC_WIDTH-1:0] y_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    rot_active
);

  localparam int W  = CORDIC_WIDTH;
  localparam int IW = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
    S_SCALE  = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] x_sh, y_sh;
  logic [N_ITER-1:0]   dir_q, dir_d;
  logic [IW-1:0]       i_q, i_d;
  logic                last_iter;
  logic                accept;

  assign last_iter = (i_q == IW'(N_ITER - 1));
  assign accept    = in_valid && in_ready;
  assign x_sh      = x_q >>> i_q;
  assign y_sh      = y_q >>> i_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      i_q     <= i_d;
    end
  end

  // Next-state logic; enable low overrides everything
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) state_d = S_ROTATE;
        end
        S_ROTATE: begin
`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
          if (last_iter) state_d = S_SCALE;
`else
          if (last_iter) state_d = S_DONE;
`endif
        end
`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
        S_SCALE: state_d = S_DONE;
`endif
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: capture, micro-rotate, optional gain trim
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    i_d   = i_q;
    if (!enable) begin
      x_d   = '0;
      y_d   = '0;
      dir_d = '0;
      i_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_d   = x_in;
            y_d   = y_in;
            dir_d = microRot_dir_in;
            i_d   = '0;
          end
        end
        S_ROTATE: begin
          if (dir_q[0]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
          end
          dir_d = dir_q >> 1;
          if (!last_iter) i_d = i_q + IW'(1);
        end
`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
        S_SCALE: begin
          x_d = (x_q >>> 1) + (x_q >>> 3)
              - (x_q >>> 6) - (x_q >>> 9);
          y_d = (y_q >>> 1) + (y_q >>> 3)
              - (y_q >>> 6) - (y_q >>> 9);
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; results masked unless valid
  always_comb begin
    in_ready   = nreset && enable && (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    rot_active = (state_q == S_ROTATE);
`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
    if (state_q == S_SCALE) rot_active = 1'b1;
`endif
    x_out = out_valid ? x_q : '0;
    y_out = out_valid ? y_q : '0;
  end

endmodule

// File: tb/tb_cordic_rot_sequencer.sv
// Directed bench for cordic_rot_sequencer, N_ITER=4.
// Expectations follow CORDIC_ROT_SEQ_SCALE_COMP_EN when defined.
module tb_cordic_rot_sequencer;

  localparam int W = 22;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         nreset;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [N-1:0] dir_in;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic         out_valid;
  logic         out_ready;
  logic         rot_active;

  int total = 0;
  int bad   = 0;

  cordic_rot_sequencer #(.CORDIC_WIDTH(W), .N_ITER(N)) dut (
    .clk(clk),
    .nreset(nreset),
    .enable(enable),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_in(x_in),
    .y_in(y_in),
    .microRot_dir_in(dir_in),
    .x_out(x_out),
    .y_out(y_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rot_active(rot_active)
  );

  always #5 clk = ~clk;

`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif

  function automatic logic signed [63:0] kscale(
    input logic signed [63:0] v);
`ifdef CORDIC_ROT_SEQ_SCALE_COMP_EN
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic start_job(input int x, input int y,
                           input logic [N-1:0] d);
    @(negedge clk);
    x_in     = W'(x);
    y_in     = W'(y);
    dir_in   = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input string tag,
                         input int x, input int y,
                         input logic [N-1:0] d,
                         input int ex, input int ey,
                         input bit noise);
    int n;
    start_job(x, y, d);
    if (noise) begin
      in_valid = 1'b1;
      x_in     = W'(999);
      y_in     = W'(77);
      dir_in   = '1;
    end
    @(negedge clk);
    chk({tag, "_active"}, 64'(rot_active), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    chk({tag, "_x"}, $signed(x_out), kscale(64'(ex)));
    chk({tag, "_y"}, $signed(y_out), kscale(64'(ey)));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    chk({tag, "_rdy_busy"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_ov_after"}, 64'(out_valid), 64'd0);
    chk({tag, "_x_after"}, $signed(x_out), 64'sd0);
  endtask

  initial begin
    logic [W-1:0] hx, hy;
    bit seen;
    nreset    = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    dir_in    = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rot_active", 64'(rot_active), 64'd0);
    chk("rst_x", $signed(x_out), 64'sd0);
    chk("rst_y", $signed(y_out), 64'sd0);
    nreset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_job("d0", 256, 0, 4'b0000, -20, -420, 1'b0);
    consume("d0");

    run_job("d1", 256, 0, 4'b1111, -20, 420, 1'b0);
    consume("d1");

    run_job("hold", 256, 0, 4'b0000, -20, -420, 1'b1);
    hx = x_out;
    hy = y_out;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_x", $signed(x_out), $signed(hx));
      chk("hold_y", $signed(y_out), $signed(hy));
      chk("hold_rdy", 64'(in_ready), 64'd0);
      chk("hold_ov", 64'(out_valid), 64'd1);
    end
    consume("hold");

    start_job(256, 0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("en_ov", 64'(out_valid), 64'd0);
    chk("en_act", 64'(rot_active), 64'd0);
    chk("en_x", $signed(x_out), 64'sd0);
    chk("en_y", $signed(y_out), 64'sd0);
    chk("en_rdy_low", 64'(in_ready), 64'd0);
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("en_no_result", 64'(seen), 64'd0);
    chk("en_rdy_idle", 64'(in_ready), 64'd1);

    start_job(256, 0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("mrst_act", 64'(rot_active), 64'd0);
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    run_job("post_rst", 256, 0, 4'b0000, -20, -420, 1'b0);
    consume("post_rst");

    run_job("big", 1024, 0, 4'b0000, -80, -1680, 1'b0);
    consume("big");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_rot_sequencer.md
CORDIC_ROT_SEQUENCER -- requirements
Module: cordic_rot_sequencer

Interface
REQ-001 The block SHALL have parameter CORDIC_WIDTH, default 22: signed datapath width of x/y.
REQ-002 The block SHALL have parameter N_ITER, default 16: micro-rotations per job (range 1..CORDIC_WIDTH-1).
REQ-003 The block SHALL have port clk  in  1: the only clock, rising-edge.
REQ-004 The block SHALL have port nreset  in  1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable  in  1: when low, synchronously aborts any job.
REQ-006 The block SHALL have port in_valid  in  1: job request.
REQ-007 The block SHALL have port in_ready  out  1: job can be accepted.
REQ-008 The block SHALL have port x_in  in  CORDIC_WIDTH: signed x operand.
REQ-009 The block SHALL have port y_in  in  CORDIC_WIDTH: signed y operand.
REQ-010 The block SHALL have port microRot_dir_in  in  N_ITER: direction bits; bit i is used at iteration i.
REQ-011 The block SHALL have port x_out  out  CORDIC_WIDTH: signed rotated x.
REQ-012 The block SHALL have port y_out  out  CORDIC_WIDTH: signed rotated y.
REQ-013 The block SHALL have port out_valid  out  1: result available.
REQ-014 The block SHALL have port out_ready  in  1: consumer accepts the result.
REQ-015 The block SHALL have port rot_active  out  1: high while iterating (ROTATE or SCALE).

Function
REQ-016 The FSM SHALL have states IDLE, ROTATE, SCALE (compiled in only with the macro) and DONE.
REQ-017 in_ready SHALL equal (state==IDLE && enable); a job is accepted on a rising edge with in_valid && in_ready.
REQ-018 On acceptance, the block SHALL capture x_in, y_in and microRot_dir_in, clear the iteration counter i, and enter ROTATE.
REQ-019 Each ROTATE cycle SHALL perform one iteration using the pre-edge x,y simultaneously: dir=0 -> x'=x+(y>>>i), y'=y-(x>>>i); dir=1 -> x'=x-(y>>>i), y'=y+(x>>>i).
REQ-020 Shifts SHALL be arithmetic and sums SHALL wrap modulo 2^CORDIC_WIDTH with no saturation; iteration 0 SHALL be unshifted (±45 degrees).
REQ-021 After iteration N_ITER-1 the FSM SHALL go to DONE (or to SCALE when configured); the counter SHALL NOT wrap.
REQ-022 Latency from the acceptance edge to out_valid high SHALL be exactly N_ITER cycles (N_ITER+1 with scaling).
REQ-023 In DONE, out_valid SHALL be high and x_out/y_out SHALL hold stable until out_valid && out_ready, after which the FSM SHALL return to IDLE on that edge.
REQ-024 A new job SHALL NOT be accepted in the same cycle a result is consumed; in_ready SHALL rise the following cycle.
REQ-025 in_valid while busy SHALL be ignored without affecting the running job.
REQ-026 enable low on any edge SHALL force IDLE, zero x_out/y_out, and clear out_valid and rot_active, overriding all other events.
REQ-027 x_out/y_out SHALL read zero whenever out_valid is low.

Reset
REQ-028 While nreset is low, the block SHALL be in state IDLE, with the counter, internal x/y, x_out, y_out, out_valid and rot_active all 0; in_ready SHALL be 0 during reset.
REQ-029 Reset asserted mid-job SHALL discard the job with no output; the first job after release SHALL behave identically to one issued after power-up.

Configuration
REQ-030 With macro CORDIC_ROT_SEQ_SCALE_COMP_EN defined, a SCALE state SHALL follow ROTATE for one cycle, multiplying x and y by K via v'=(v>>>1)+(v>>>3)-(v>>>6)-(v>>>9).
REQ-031 Without CORDIC_ROT_SEQ_SCALE_COMP_EN, no SCALE state or logic SHALL exist and the results SHALL carry the raw CORDIC gain.

Verification
REQ-032 The bench SHALL cover: N_ITER=4, no macro, x=256, y=0, dir=4'b0000 -> out_valid exactly 4 cycles after accept, x_out=-20, y_out=-420.
REQ-033 The bench SHALL cover: same job with dir=4'b1111 -> x_out=-20, y_out=420.
REQ-034 The bench SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable and in_ready low throughout; out_ready=1 -> in_ready=1 on the next cycle.
REQ-035 The bench SHALL cover: enable dropped at iteration 2 -> next edge IDLE, out_valid=0, x_out=y_out=0, and no result emitted.
REQ-036 The bench SHALL cover: nreset pulsed mid-ROTATE, then a fresh job x=256, y=0, dir=0 -> (-20,-420).
REQ-037 The bench SHALL cover: macro defined, x=1024 (N_ITER=4, dir=0) -> latency 5 and result equal to the unscaled result passed through the REQ-030 expression.
